processor_run_controller: RTL



---
 rtl/processor_pkg.sv | 20 ++
 rtl/sat_counter.sv | 23 ++
 rtl/processor_run_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared types and defaults for the processor run-sequencing logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package processor_pkg;

   localparam int CYCLE_COUNT_W      = 16;
   localparam int RESET_CYCLES_DEF   = 2;
   localparam int DRAIN_CYCLES_DEF   = 4;
   localparam int TIMEOUT_CYCLES_DEF = 1023;

   // Encodings are visible on state_out, so they are fixed explicitly.
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RESET_CORE = 3'd1,
      ST_RUN        = 3'd2,
      ST_DRAIN      = 3'd3,
      ST_DONE       = 3'd4
   } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Latency: count reflects clear/enable one edge later.
// Backpressure: none; enable is a plain qualifier.
// Ports: clock, reset (sync, active-high), clear (beats enable), enable, count.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/processor_run_controller.sv
// Run sequencer for the core: reset, run until instr_stop, drain pipeline, freeze.
// Latency: state/flags registered (1 edge); core_enable is combinational from step.
// Backpressure: in step mode the core only advances on cycles where step is high.
// Ports: clock, reset, start, abort, step_mode, step, instr_stop in;
//        core_reset, core_enable, busy, done, timeout, cycle_count[15:0], state_out[2:0] out.
module processor_run_controller
   import processor_pkg::*;
#(
   parameter int RESET_CYCLES   = RESET_CYCLES_DEF,
   parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     step_mode,
   input  logic                     step,
   input  logic                     instr_stop,
   output logic                     core_reset,
   output logic                     core_enable,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [CYCLE_COUNT_W-1:0] cycle_count,
   output logic [2:0]               state_out
);

   localparam logic [2:0]               RESET_LAST   = 3'(RESET_CYCLES - 1);
   localparam logic [2:0]               DRAIN_LAST   = 3'(DRAIN_CYCLES - 1);
   localparam logic [CYCLE_COUNT_W-1:0] TIMEOUT_LAST = CYCLE_COUNT_W'(TIMEOUT_CYCLES - 1);

   run_state_t state, state_next;
   logic [2:0] phase_cnt;
   logic       step_mode_q;
   logic       start_acc;
   logic       timeout_set;
   logic       count_inc;
   logic       phase_adv;

   // Core enable: always on while the core is held in reset so its registers
   // actually load reset values; follows step in step mode during RUN/DRAIN.
   always_comb begin
      core_enable = 1'b0;
      case (state)
         ST_RESET_CORE:     core_enable = 1'b1;
         ST_RUN, ST_DRAIN:  core_enable = step_mode_q ? step : 1'b1;
         default:           core_enable = 1'b0;
      endcase
   end

   always_comb begin
      state_next  = state;
      start_acc   = 1'b0;
      timeout_set = 1'b0;
      count_inc   = 1'b0;
      if (abort) begin
         // Abort freezes the count and leaves the timeout flag as it was.
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_next = ST_RESET_CORE;
                  start_acc  = 1'b1;
               end
            end
            ST_RESET_CORE: begin
               if (phase_cnt == RESET_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
               count_inc = core_enable;
               if (core_enable) begin
                  // instr_stop wins over the watchdog on the same cycle.
                  if (instr_stop) begin
                     state_next = ST_DRAIN;
                  end else if (cycle_count == TIMEOUT_LAST) begin
                     state_next  = ST_DONE;
                     timeout_set = 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               count_inc = core_enable;
               if (core_enable && (phase_cnt == DRAIN_LAST)) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign phase_adv = (state == ST_RESET_CORE) || ((state == ST_DRAIN) && core_enable);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         phase_cnt   <= '0;
         step_mode_q <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state <= state_next;
         // Phase counter restarts on every state change so RESET_CORE and
         // DRAIN each count from zero.
         if (state_next != state) begin
            phase_cnt <= '0;
         end else if (phase_adv) begin
            phase_cnt <= phase_cnt + 3'd1;
         end
         if (start_acc) begin
            step_mode_q <= step_mode;
            timeout     <= 1'b0;
         end else if (timeout_set) begin
            timeout <= 1'b1;
         end
      end
   end

   sat_counter #(
      .WIDTH (CYCLE_COUNT_W)
   ) u_cycle_count (
      .clock  (clock),
      .reset  (reset),
      .clear  (start_acc),
      .enable (count_inc),
      .count  (cycle_count)
   );

   assign core_reset = (state == ST_IDLE) || (state == ST_RESET_CORE);
   assign busy       = (state == ST_RESET_CORE) || (state == ST_RUN) || (state == ST_DRAIN);
   assign done       = (state == ST_DONE);
   assign state_out  = state;

endmodule
